// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port block-memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_BLOCK_W = 128;
    localparam int BLK_OFF_W   = 4;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle of the arbiter; slave is the arbiter's view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BLOCK_W = DEF_BLOCK_W
);
    logic               req0;
    logic               req1;
    logic               we0;
    logic               we1;
    logic [ADDR_W-1:0]  addr0;
    logic [ADDR_W-1:0]  addr1;
    logic [BLOCK_W-1:0] wdata0;
    logic [BLOCK_W-1:0] wdata1;
    logic               ready0;
    logic               ready1;
    logic [BLOCK_W-1:0] rdata0;
    logic [BLOCK_W-1:0] rdata1;
    logic               busy;
    logic               mem_read_write;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_write_data;
    logic [BLOCK_W-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        output ready0, ready1, rdata0, rdata1, busy,
               mem_read_write, mem_address, mem_write_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
        input  ready0, ready1, rdata0, rdata1, busy,
               mem_read_write, mem_address, mem_write_data
    );

endinterface

// File: rtl/mem_rr_arbiter.sv
// Combinational two-way round-robin grant; the last-grant history is held by the caller.
module mem_rr_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_o
);

    // Tie goes to the port that did not win last time
    always_comb begin
        grant_valid_o = req0_i | req1_i;
        grant_o       = PORT_I;
        if (req0_i && req1_i) begin
            grant_o = (last_grant_i == PORT_I) ? PORT_D : PORT_I;
        end else if (req1_i) begin
            grant_o = PORT_D;
        end else begin
            grant_o = PORT_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and fixed-latency access sequencer between the I/D caches
// and the shared block memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BLOCK_W = DEF_BLOCK_W
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int                 BLK_W    = ADDR_W - BLK_OFF_W;
    localparam int                 CNT_W    = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_grant_q, last_grant_d;
    logic               gnt_port_q, gnt_port_d;
    logic               we_q, we_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLOCK_W-1:0] wdata_q, wdata_d;
    logic [BLOCK_W-1:0] rdata0_q, rdata0_d;
    logic [BLOCK_W-1:0] rdata1_q, rdata1_d;
    logic               ready0_q, ready0_d;
    logic               ready1_q, ready1_d;
    logic               busy_q, busy_d;
    logic               mem_rw_q, mem_rw_d;
    logic               arb_valid_s;
    logic               arb_port_s;

    mem_rr_arbiter u_rr (
        .req0_i        (bus.req0),
        .req1_i        (bus.req1),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (arb_valid_s),
        .grant_o       (arb_port_s)
    );

    // Next-state, request latching and registered-output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        gnt_port_d   = gnt_port_q;
        we_d         = we_q;
        blk_d        = blk_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;

        case (state_q)
            IDLE: begin
                if (arb_valid_s) begin
                    state_d      = BUSY;
                    cnt_d        = CNT_LOAD;
                    last_grant_d = arb_port_s;
                    gnt_port_d   = arb_port_s;
                    if (arb_port_s == PORT_D) begin
                        we_d    = bus.we1;
                        blk_d   = bus.addr1[ADDR_W-1:BLK_OFF_W];
                        wdata_d = bus.wdata1;
                    end else begin
                        we_d    = bus.we0;
                        blk_d   = bus.addr0[ADDR_W-1:BLK_OFF_W];
                        wdata_d = bus.wdata0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    // Read data is sampled only at the edge closing the last access cycle
                    if (!we_q && (gnt_port_q == PORT_D)) begin
                        rdata1_d = bus.mem_read_data;
                    end else if (!we_q) begin
                        rdata0_d = bus.mem_read_data;
                    end else begin
                        rdata0_d = rdata0_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d   = (state_d != IDLE);
        ready0_d = (state_d == DONE) && (gnt_port_d == PORT_I);
        ready1_d = (state_d == DONE) && (gnt_port_d == PORT_D);
        mem_rw_d = (state_d == BUSY) && (cnt_d == '0) && we_d;
    end

    // State and output registers; reset clears the strobe without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= PORT_D;
            gnt_port_q   <= PORT_I;
            we_q         <= 1'b0;
            blk_q        <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            busy_q       <= 1'b0;
            mem_rw_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            gnt_port_q   <= gnt_port_d;
            we_q         <= we_d;
            blk_q        <= blk_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            busy_q       <= busy_d;
            mem_rw_q     <= mem_rw_d;
        end
    end

    assign bus.ready0         = ready0_q;
    assign bus.ready1         = ready1_q;
    assign bus.rdata0         = rdata0_q;
    assign bus.rdata1         = rdata1_q;
    assign bus.busy           = busy_q;
    assign bus.mem_read_write = mem_rw_q;
    assign bus.mem_address    = {blk_q, BLK_OFF_W'(0)};
    assign bus.mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LATENCY=4 main instance plus a LATENCY=1 build.
module tb_mem_arbiter;

    localparam int L = 4;

    typedef struct {
        int           port;
        bit           we;
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   strobe_cnt = 0;
    int   strobe_cyc = -1;
    exp_t sb[$];

    logic [127:0] wr_mem [64];
    bit   [63:0]  wr_valid;

    mem_arbiter_if #(.ADDR_W(10), .BLOCK_W(128)) m ();
    mem_arbiter_if #(.ADDR_W(10), .BLOCK_W(128)) m1 ();

    mem_arbiter #(.LATENCY(L), .ADDR_W(10), .BLOCK_W(128)) dut (
        .clk(clk), .reset(reset), .bus(m)
    );
    mem_arbiter #(.LATENCY(1), .ADDR_W(10), .BLOCK_W(128)) dut1 (
        .clk(clk), .reset(reset), .bus(m1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] init_block(input logic [5:0] idx);
        logic [31:0] w;
        w = 32'hC0DE_0000 | {26'd0, idx};
        return {w, ~w, w ^ 32'h1357_9BDF, {idx, 26'h0}};
    endfunction

    function automatic logic [127:0] model_rd(input logic [5:0] idx);
        return wr_valid[idx] ? wr_mem[idx] : init_block(idx);
    endfunction

    assign m.mem_read_data  = wr_valid[m.mem_address[9:4]] ? wr_mem[m.mem_address[9:4]]
                                                           : init_block(m.mem_address[9:4]);
    assign m1.mem_read_data = init_block(m1.mem_address[9:4]);

    always @(posedge clk) begin
        if (m.mem_read_write) begin
            wr_mem[m.mem_address[9:4]]   <= m.mem_write_data;
            wr_valid[m.mem_address[9:4]] <= 1'b1;
        end
    end

    // Completion monitor: every ready pulse is matched against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (m.mem_read_write) begin
            strobe_cnt++;
            strobe_cyc = cyc;
        end
        if (m.ready0 || m.ready1) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_ready: got ready0=%0b ready1=%0b at cycle %0d, expected none",
                         m.ready0, m.ready1, cyc);
            end else begin
                e = sb.pop_front();
                if ((m.ready0 && m.ready1) || (e.port == 0 ? !m.ready0 : !m.ready1) || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL ready_port_cycle: got ready0=%0b ready1=%0b cycle %0d, expected port %0d cycle %0d",
                             m.ready0, m.ready1, cyc, e.port, e.cyc);
                end
                if (!e.we) begin
                    n_vec++;
                    if ((e.port == 0 ? m.rdata0 : m.rdata1) !== e.data) begin
                        n_err++;
                        $display("FAIL rdata_port%0d: got %h expected %h", e.port,
                                 (e.port == 0 ? m.rdata0 : m.rdata1), e.data);
                    end
                end
            end
        end
    end

    task automatic issue(input int p, input bit w, input logic [9:0] a, input logic [127:0] d,
                         input bit push, input int exp_cyc);
        exp_t e;
        if (p == 0) begin
            m.req0 = 1'b1; m.we0 = w; m.addr0 = a; m.wdata0 = d;
        end else begin
            m.req1 = 1'b1; m.we1 = w; m.addr1 = a; m.wdata1 = d;
        end
        if (push) begin
            e.port = p; e.we = w; e.cyc = exp_cyc;
            e.data = w ? 128'd0 : model_rd(a[9:4]);
            sb.push_back(e);
        end
    endtask

    task automatic run_until_idle(input int budget);
        int k = 0;
        while ((m.req0 || m.req1) && k < budget) begin
            @(negedge clk);
            k++;
            if (m.ready0) m.req0 = 1'b0;
            if (m.ready1) m.req1 = 1'b0;
        end
        if (m.req0 || m.req1) begin
            n_vec++; n_err++;
            $display("FAIL completion_timeout: got req0=%0b req1=%0b after %0d cycles, expected both served",
                     m.req0, m.req1, budget);
            m.req0 = 1'b0; m.req1 = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({m.ready0, m.ready1, m.busy, m.mem_read_write, m.mem_address, m.mem_write_data,
             m.rdata0, m.rdata1} !== '0) begin
            n_err++;
            $display("FAIL reset_in_reset: got busy=%0b rw=%0b addr=%h, expected all zero",
                     m.busy, m.mem_read_write, m.mem_address);
        end
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({m.ready0, m.ready1, m.busy, m.mem_read_write, m.mem_address, m.mem_write_data,
             m.rdata0, m.rdata1, m1.ready0, m1.busy, m1.rdata0} !== '0) begin
            n_err++;
            $display("FAIL reset_after_release: got busy=%0b busy1=%0b rw=%0b, expected all zero",
                     m.busy, m1.busy, m.mem_read_write);
        end
    endtask

    task automatic test_tie(input int first);
        int t = cyc;
        int second = 1 - first;
        issue(first,  1'b0, (first == 0)  ? 10'h040 : 10'h08C, 128'd0, 1'b1, t + L + 1);
        issue(second, 1'b0, (second == 0) ? 10'h040 : 10'h08C, 128'd0, 1'b1, t + 2*L + 3);
        run_until_idle(40);
    endtask

    task automatic test_read();
        int t = cyc;
        issue(0, 1'b0, 10'h0C7, 128'd0, 1'b1, t + L + 1);
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            n_vec++;
            if ({m.busy, m.mem_address, m.mem_read_write} !== {1'b1, 10'h0C0, 1'b0}) begin
                n_err++;
                $display("FAIL read_busy_cycle%0d: got busy=%0b addr=%h rw=%0b, expected 1/0c0/0",
                         i, m.busy, m.mem_address, m.mem_read_write);
            end
        end
        run_until_idle(20);
        n_vec++;
        if (m.rdata0 !== init_block(6'h0C)) begin
            n_err++;
            $display("FAIL read_rdata_held: got %h expected %h", m.rdata0, init_block(6'h0C));
        end
    endtask

    task automatic test_write_read();
        logic [127:0] wd = {96'h0123_4567_89AB_CDEF_0F1E_2D3C, 32'hDEAD_BEEF};
        int t = cyc;
        int s0 = strobe_cnt;
        issue(1, 1'b1, 10'h210, wd, 1'b1, t + L + 1);
        run_until_idle(20);
        n_vec++;
        if (strobe_cnt - s0 != 1 || strobe_cyc != t + L) begin
            n_err++;
            $display("FAIL write_strobe: got %0d pulses last at %0d, expected 1 at %0d",
                     strobe_cnt - s0, strobe_cyc, t + L);
        end
        n_vec++;
        if (!wr_valid[6'h21] || wr_mem[6'h21] !== wd) begin
            n_err++;
            $display("FAIL write_memory: got %h expected %h", wr_mem[6'h21], wd);
        end
        t = cyc;
        issue(1, 1'b0, 10'h21C, 128'd0, 1'b1, t + L + 1);
        run_until_idle(20);
    endtask

    task automatic test_back_to_back();
        int t = cyc;
        issue(0, 1'b0, 10'h300, 128'd0, 1'b1, t + L + 1);
        @(negedge clk);
        issue(1, 1'b0, 10'h3F5, 128'd0, 1'b1, t + 2*L + 3);
        run_until_idle(40);
    endtask

    task automatic test_reset_mid_write();
        int s0 = strobe_cnt;
        issue(1, 1'b1, 10'h1A0, {4{32'hFACE_0FF0}}, 1'b0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m.req1 = 1'b0;
        #1;
        n_vec++;
        if ({m.busy, m.mem_read_write, m.ready0, m.ready1, m.mem_address} !== '0) begin
            n_err++;
            $display("FAIL reset_abort_outputs: got busy=%0b rw=%0b addr=%h, expected all zero",
                     m.busy, m.mem_read_write, m.mem_address);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (L + 2) @(negedge clk);
        n_vec++;
        if (strobe_cnt != s0 || wr_valid[6'h1A] || m.busy) begin
            n_err++;
            $display("FAIL reset_abort_effects: got strobes=%0d written=%0b busy=%0b, expected 0/0/0",
                     strobe_cnt - s0, wr_valid[6'h1A], m.busy);
        end
    endtask

    task automatic test_latency1();
        m1.req0 = 1'b1; m1.we0 = 1'b0; m1.addr0 = 10'h355;
        @(negedge clk);
        n_vec++;
        if ({m1.busy, m1.mem_address, m1.ready0, m1.mem_read_write} !== {1'b1, 10'h350, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL lat1_busy: got busy=%0b addr=%h ready=%0b, expected 1/350/0",
                     m1.busy, m1.mem_address, m1.ready0);
        end
        @(negedge clk);
        n_vec++;
        if (m1.ready0 !== 1'b1 || m1.rdata0 !== init_block(6'h35)) begin
            n_err++;
            $display("FAIL lat1_ready: got ready=%0b rdata=%h expected 1 %h",
                     m1.ready0, m1.rdata0, init_block(6'h35));
        end
        m1.req0 = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({m1.ready0, m1.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL lat1_idle: got ready=%0b busy=%0b expected 0/0", m1.ready0, m1.busy);
        end
    endtask

    initial begin
        m.req0 = 1'b0; m.req1 = 1'b0; m.we0 = 1'b0; m.we1 = 1'b0;
        m.addr0 = 10'd0; m.addr1 = 10'd0; m.wdata0 = 128'd0; m.wdata1 = 128'd0;
        m1.req0 = 1'b0; m1.req1 = 1'b0; m1.we0 = 1'b0; m1.we1 = 1'b0;
        m1.addr0 = 10'd0; m1.addr1 = 10'd0; m1.wdata0 = 128'd0; m1.wdata1 = 128'd0;

        test_reset();
        test_tie(0);
        test_read();
        test_tie(1);
        test_write_read();
        test_back_to_back();
        test_reset_mid_write();
        test_latency1();

        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish by 200000, expected earlier end");
        $fatal(1, "timeout");
    end

endmodule
